// File: rtl/lfsr_pkg.sv
// Shared constants and types for the LFSR shift engine and its upstream
// shift-magnitude calculator.
package lfsr_pkg;
   localparam int              LFSR_WIDTH  = 16;
   localparam logic [15:0]     LFSR_TAPS   = 16'hB400;
   localparam int              SHIFT_MAG_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } lfsr_state_e;
endpackage

// File: rtl/lfsr_step.sv
// One combinational Galois LFSR step: shift right, fold TAPS in when the
// bit shifted out was set.
module lfsr_step #(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] TAPS  = 16'hB400
) (
   input  logic [WIDTH-1:0] i_state,
   output logic [WIDTH-1:0] o_next
);
   logic [WIDTH-1:0] w_shr;

   assign w_shr  = i_state >> 1;
   assign o_next = i_state[0] ? (w_shr ^ TAPS) : w_shr;
endmodule

// File: rtl/lfsr_shift_engine.sv
// Sequential LFSR advance engine: loads a seed, advances it shift_mag steps
// one per cycle, then holds the result on a valid/ready output.
module lfsr_shift_engine
   import lfsr_pkg::*;
#(
   parameter int               WIDTH = LFSR_WIDTH,
   parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       seed,
   input  logic [SHIFT_MAG_W-1:0] shift_mag,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       result,
   output logic                   busy
);
   lfsr_state_e            r_fsm;
   logic [WIDTH-1:0]       r_state;
   logic [SHIFT_MAG_W-1:0] r_count;
   logic                   r_in_ready;
   logic                   r_out_valid;
   logic                   r_busy;
   logic [WIDTH-1:0]       w_next;

   lfsr_step #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
   ) u_step (
      .i_state (r_state),
      .o_next  (w_next)
   );

   // Handshake outputs are registered alongside the state so they change
   // only on the edge that moves the FSM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fsm       <= IDLE;
         r_state     <= '0;
         r_count     <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_fsm)
            IDLE: begin
               if (in_valid) begin
                  r_state    <= seed;
                  r_count    <= shift_mag;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  if (shift_mag == '0) begin
                     r_fsm       <= DONE;
                     r_out_valid <= 1'b1;
                  end else begin
                     r_fsm <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               r_state <= w_next;
               r_count <= r_count - SHIFT_MAG_W'(1);
               if (r_count == SHIFT_MAG_W'(1)) begin
                  r_fsm       <= DONE;
                  r_out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_fsm       <= IDLE;
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end
            default: begin
               r_fsm       <= IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign result    = r_state;
endmodule
